// File: rtl/pg_config_sequencer.sv
// Writes a snapshotted pulse configuration into one pulse generator register file.
// Optional read-back verification is enabled by defining PG_CONFIG_SEQ_VERIFY_EN.
`ifndef PG0_PULSE_ENA
`define PG0_PULSE_ENA 8'h20
`endif

module pg_config_sequencer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(`PG0_PULSE_ENA)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [DATA_WIDTH-1:0]   i_cfg_enable,
  input  logic [2*DATA_WIDTH-1:0] i_cfg_year,
  input  logic [DATA_WIDTH-1:0]   i_cfg_month,
  input  logic [DATA_WIDTH-1:0]   i_cfg_day,
  input  logic [DATA_WIDTH-1:0]   i_cfg_hour,
  input  logic [DATA_WIDTH-1:0]   i_cfg_minutes,
  input  logic [DATA_WIDTH-1:0]   i_cfg_seconds,
  input  logic [4*DATA_WIDTH-1:0] i_cfg_width_high,
  input  logic [4*DATA_WIDTH-1:0] i_cfg_width_period,
  input  logic                    i_host_wr,
  input  logic [ADDR_WIDTH-1:0]   i_host_addr,
  input  logic [DATA_WIDTH-1:0]   i_host_data,
  output logic                    o_host_stall,
  output logic                    o_wr,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic [DATA_WIDTH-1:0]   o_data,
  input  logic [DATA_WIDTH-1:0]   i_rd_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error
);

  localparam int         DW       = DATA_WIDTH;
  localparam int         NREG     = 16;
  localparam logic [4:0] LAST_IDX = 5'd16;

`ifdef PG_CONFIG_SEQ_VERIFY_EN
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [DW-1:0]   shad_q [NREG];
  logic [DW-1:0]   shad_d [NREG];
  logic            err_q, err_d;
  logic            cfg_ok;

  // Slot 0 of the shadow holds the final enable so that offset k maps directly.
  assign cfg_ok  = (i_cfg_width_period != '0) && (i_cfg_width_high < i_cfg_width_period);
  assign o_error = err_q;

`ifdef PG_CONFIG_SEQ_VERIFY_EN
  logic            mis_q, mis_d;
  logic [3:0]      rd_off;
  logic            rd_miss;

  // Read data lags the presented address by one cycle, so compare the previous offset.
  assign rd_off  = idx_q[3:0] - 4'd1;
  assign rd_miss = (idx_q != 5'd0) && (i_rd_data != shad_q[rd_off]);

  always_ff @(posedge i_clk) begin
    if (!i_rst) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
`else
  logic unused_rd;
  assign unused_rd = ^i_rd_data;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      shad_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      shad_q  <= shad_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    err_d        = err_q;
    shad_d       = shad_q;
`ifdef PG_CONFIG_SEQ_VERIFY_EN
    mis_d        = mis_q;
`endif
    o_wr         = 1'b0;
    o_addr       = BASE_ADDR;
    o_data       = '0;
    o_host_stall = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;

    case (state_q)
      IDLE: begin
        o_wr   = i_host_wr;
        o_addr = i_host_addr;
        o_data = i_host_data;
        if (i_start) begin
          shad_d[0] = i_cfg_enable;
          shad_d[1] = i_cfg_year[2*DW-1:DW];
          shad_d[2] = i_cfg_year[DW-1:0];
          shad_d[3] = i_cfg_month;
          shad_d[4] = i_cfg_day;
          shad_d[5] = i_cfg_hour;
          shad_d[6] = i_cfg_minutes;
          shad_d[7] = i_cfg_seconds;
          for (int j = 0; j < 4; j++) begin
            shad_d[8+j]  = i_cfg_width_high[(3-j)*DW +: DW];
            shad_d[12+j] = i_cfg_width_period[(3-j)*DW +: DW];
          end
          idx_d = '0;
`ifdef PG_CONFIG_SEQ_VERIFY_EN
          mis_d = 1'b0;
`endif
          if (cfg_ok) begin
            err_d   = 1'b0;
            state_d = WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      WRITE: begin
        o_wr         = 1'b1;
        o_busy       = 1'b1;
        o_host_stall = 1'b1;
        o_addr       = BASE_ADDR + ADDR_WIDTH'(idx_q[3:0]);
        // Index 0 disables the block; index 16 wraps to offset 0 and writes the enable.
        o_data       = (idx_q == 5'd0) ? '0 : shad_q[idx_q[3:0]];
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
`ifdef PG_CONFIG_SEQ_VERIFY_EN
          state_d = READ;
`else
          state_d = DONE;
`endif
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end

`ifdef PG_CONFIG_SEQ_VERIFY_EN
      READ: begin
        o_busy       = 1'b1;
        o_host_stall = 1'b1;
        o_addr       = BASE_ADDR + ADDR_WIDTH'(idx_q[3:0]);
        if (idx_q == LAST_IDX) begin
          err_d   = mis_q | rd_miss;
          state_d = DONE;
        end else begin
          mis_d = mis_q | rd_miss;
          idx_d = idx_q + 5'd1;
        end
      end
`endif

      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pg_config_sequencer.sv
// Scoreboard bench for pg_config_sequencer; expected bus writes are queued at stimulus time.
module tb_pg_config_sequencer;

  localparam int            DW   = 8;
  localparam int            AW   = 8;
  localparam logic [AW-1:0] BASE = 8'h40;
`ifdef PG_CONFIG_SEQ_VERIFY_EN
  localparam int LAT      = 35;
  localparam int BUSY_CYC = 34;
`else
  localparam int LAT      = 18;
  localparam int BUSY_CYC = 17;
`endif

  typedef struct {
    logic [7:0]  en;
    logic [15:0] year;
    logic [7:0]  mon, day, hr, mi, se;
    logic [31:0] hi, pe;
  } cfg_t;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] cfg_en = '0, cfg_mon = '0, cfg_day = '0, cfg_hr = '0, cfg_mi = '0, cfg_se = '0;
  logic [15:0]   cfg_year = '0;
  logic [31:0]   cfg_hi = '0, cfg_pe = '0;
  logic          host_wr = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;
  logic          o_host_stall, o_wr, o_busy, o_done, o_error;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic [DW-1:0] rd_q = '0;

  pg_config_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst(rst_b), .i_start(start),
    .i_cfg_enable(cfg_en), .i_cfg_year(cfg_year), .i_cfg_month(cfg_mon),
    .i_cfg_day(cfg_day), .i_cfg_hour(cfg_hr), .i_cfg_minutes(cfg_mi),
    .i_cfg_seconds(cfg_se), .i_cfg_width_high(cfg_hi), .i_cfg_width_period(cfg_pe),
    .i_host_wr(host_wr), .i_host_addr(host_addr), .i_host_data(host_data),
    .o_host_stall(o_host_stall), .o_wr(o_wr), .o_addr(o_addr), .o_data(o_data),
    .i_rd_data(rd_q), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  logic [AW+DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Target register file: registered read data with optional corruption of offset 5.
  logic [DW-1:0] tgt_mem [16];
  logic          corrupt5 = 1'b0;
  logic [AW-1:0] off;
  assign off = o_addr - BASE;
  always @(posedge clk) begin
    if (o_wr && off < 8'd16) tgt_mem[off[3:0]] <= o_data;
    rd_q <= (corrupt5 && off == 8'd5) ? ~tgt_mem[off[3:0]] : tgt_mem[off[3:0]];
  end

  always @(negedge clk) begin
    if (o_wr) begin
      wr_cnt++;
      if (sb.size() == 0) chk("wr_unexpected_sb_size", 64'(sb.size()), 64'd1);
      else chk("wr_addr_data", {o_addr, o_data}, sb.pop_front());
    end
  end

  task automatic apply_cfg(input cfg_t c);
    cfg_en = c.en; cfg_year = c.year; cfg_mon = c.mon; cfg_day = c.day;
    cfg_hr = c.hr; cfg_mi = c.mi; cfg_se = c.se; cfg_hi = c.hi; cfg_pe = c.pe;
  endtask

  task automatic push_exp(input cfg_t c);
    logic [DW-1:0] v [17];
    v[0] = 8'h00; v[1] = c.year[15:8]; v[2] = c.year[7:0];
    v[3] = c.mon; v[4] = c.day; v[5] = c.hr; v[6] = c.mi; v[7] = c.se;
    v[8]  = c.hi[31:24]; v[9]  = c.hi[23:16]; v[10] = c.hi[15:8]; v[11] = c.hi[7:0];
    v[12] = c.pe[31:24]; v[13] = c.pe[23:16]; v[14] = c.pe[15:8]; v[15] = c.pe[7:0];
    v[16] = c.en;
    for (int k = 0; k < 17; k++) sb.push_back({BASE + 8'(k % 16), v[k]});
  endtask

  task automatic run_seq(input cfg_t c, input bit exp_err, input bit host_noise);
    int   lat = 0;
    int   stall_cnt = 0;
    logic busy_at_done = 1'b1;
    cfg_t junk;
    bit   valid;
    valid = (c.pe != 0) && (c.hi < c.pe);
    junk = '{en: ~c.en, year: ~c.year, mon: ~c.mon, day: ~c.day, hr: ~c.hr,
             mi: ~c.mi, se: ~c.se, hi: ~c.hi, pe: ~c.pe};
    apply_cfg(c);
    @(posedge clk); #1;
    wr_cnt = 0;
    start  = 1'b1;
    if (host_noise) begin
      host_wr = 1'b1; host_addr = BASE + 8'd7; host_data = 8'h3C;
      sb.push_back({BASE + 8'd7, 8'h3C});
    end
    if (valid) push_exp(c);
    @(posedge clk); #1;
    start = 1'b0;
    apply_cfg(junk);
    host_addr = BASE + 8'd3; host_data = 8'hAA;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      host_wr = host_noise && (cyc <= 17);
      start   = host_noise && (cyc == 5);
      @(negedge clk);
      if (o_host_stall) stall_cnt++;
      if (o_done) begin
        lat = cyc;
        busy_at_done = o_busy;
        break;
      end
      @(posedge clk); #1;
    end
    host_wr = 1'b0;
    start   = 1'b0;
    chk("done_latency", 64'(lat), valid ? 64'(LAT) : 64'd1);
    chk("error_at_done", 64'(o_error), 64'(exp_err));
    chk("busy_at_done", 64'(busy_at_done), 64'd0);
    chk("stall_cycles", 64'(stall_cnt), valid ? 64'(BUSY_CYC) : 64'd0);
    chk("wr_count", 64'(wr_cnt), 64'((valid ? 17 : 0) + (host_noise ? 1 : 0)));
    chk("sb_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle", 64'(o_done), 64'd0);
    chk("error_held", 64'(o_error), 64'(exp_err));
  endtask

  cfg_t c_spec, c_bad, c_edge, c_zero;

  initial begin
    c_spec = '{en: 8'h01, year: 16'h07E8, mon: 8'h06, day: 8'h15, hr: 8'h0C,
               mi: 8'h1E, se: 8'h2D, hi: 32'h000F4240, pe: 32'h00989680};
    c_bad  = '{en: 8'h01, year: 16'h07E8, mon: 8'h01, day: 8'h01, hr: 8'h00,
               mi: 8'h00, se: 8'h00, hi: 32'd100, pe: 32'd100};
    c_edge = '{en: 8'hA5, year: 16'h1234, mon: 8'h0C, day: 8'h1F, hr: 8'h17,
               mi: 8'h3B, se: 8'h3A, hi: 32'hFFFFFFFE, pe: 32'hFFFFFFFF};
    c_zero = '{en: 8'h01, year: 16'h0001, mon: 8'h02, day: 8'h03, hr: 8'h04,
               mi: 8'h05, se: 8'h06, hi: 32'd0, pe: 32'd0};

    // Reset values; address/data follow the host in IDLE.
    host_addr = 8'h5A; host_data = 8'hC3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr", 64'(o_wr), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_error", 64'(o_error), 64'd0);
    chk("rst_stall", 64'(o_host_stall), 64'd0);
    chk("rst_addr", 64'(o_addr), 64'h5A);
    chk("rst_data", 64'(o_data), 64'hC3);
    @(posedge clk); #1;
    rst_b = 1'b1;

    // Host passthrough.
    @(posedge clk); #1;
    host_wr = 1'b1; host_addr = BASE + 8'd3; host_data = 8'h07;
    sb.push_back({BASE + 8'd3, 8'h07});
    @(negedge clk);
    chk("pass_stall", 64'(o_host_stall), 64'd0);
    chk("pass_addr", 64'(o_addr), 64'(BASE + 8'd3));
    chk("pass_data", 64'(o_data), 64'h07);
    @(posedge clk); #1;
    host_wr = 1'b0;

    run_seq(c_spec, 1'b0, 1'b0);
    run_seq(c_bad,  1'b1, 1'b0);
    run_seq(c_edge, 1'b0, 1'b1);
    run_seq(c_zero, 1'b1, 1'b0);

    // Reset while writing index 8.
    apply_cfg(c_spec);
    host_addr = 8'h66; host_data = 8'h99;
    @(posedge clk); #1;
    wr_cnt = 0;
    start  = 1'b1;
    push_exp(c_spec);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_wr", 64'(o_wr), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_done", 64'(o_done), 64'd0);
    chk("midrst_error", 64'(o_error), 64'd0);
    chk("midrst_stall", 64'(o_host_stall), 64'd0);
    chk("midrst_addr", 64'(o_addr), 64'h66);
    chk("midrst_wr_count", 64'(wr_cnt), 64'd9);
    chk("midrst_sb_left", 64'(sb.size()), 64'd8);
    sb.delete();
    @(posedge clk); #1;
    rst_b = 1'b1;
    run_seq(c_spec, 1'b0, 1'b0);

`ifdef PG_CONFIG_SEQ_VERIFY_EN
    corrupt5 = 1'b1;
    run_seq(c_edge, 1'b1, 1'b0);
    corrupt5 = 1'b0;
    run_seq(c_spec, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pg_config_sequencer.md
# pg_config_sequencer

Sequences a complete configuration into one pulse generator block's register file over the shared memory write bus. On a start request it snapshots a full pulse configuration, validates it, and writes it in a glitch-free order: disable, time-of-day, widths, then final enable. While idle, host register traffic passes through unchanged; while sequencing, the host is stalled. It sits between the host register interface and a pulse generator block's `i_wr/i_addr/i_data/o_data` port.

## Interface
- `BASE_ADDR`, default `` `PG0_PULSE_ENA ``: address of register offset 0 of the target block. The block's registers are contiguous at offsets 0..15: ENA, YEAR_H, YEAR_L, MONTH, DAY, HOUR, MINUTES, SECONDS, WIDTH_HIGH_3..0, WIDTH_PERIOD_3..0.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst` in 1: synchronous, active-low reset.
- `i_start` in 1: request a sequence; sampled only in IDLE.
- `i_cfg_enable` in `DATA_WIDTH`: final PULSE_ENA value.
- `i_cfg_year` in `2*DATA_WIDTH`: year value.
- `i_cfg_month`, `i_cfg_day`, `i_cfg_hour`, `i_cfg_minutes`, `i_cfg_seconds` in `DATA_WIDTH` each: time-of-day fields.
- `i_cfg_width_high`, `i_cfg_width_period` in `4*DATA_WIDTH` each: high time and period.
- `i_host_wr` in 1, `i_host_addr` in `ADDR_WIDTH`, `i_host_data` in `DATA_WIDTH`: host write bus.
- `o_host_stall` out 1: host writes are dropped while this is high.
- `o_wr` out 1, `o_addr` out `ADDR_WIDTH`, `o_data` out `DATA_WIDTH`: bus to the pulse generator block.
- `i_rd_data` in `DATA_WIDTH`: the block's `o_data`. Used only with verify.
- `o_busy` out 1: a sequence is in progress.
- `o_done` out 1: one-cycle completion pulse.
- `o_error` out 1: result flag, valid from `o_done` until the next accepted start.

## Operation
- States: IDLE, WRITE, READ (only with verify), DONE.
- **IDLE**
  - Bus is combinational passthrough: `o_wr=i_host_wr`, `o_addr=i_host_addr`, `o_data=i_host_data`, `o_host_stall=0`.
- **On `i_start` in IDLE:** snapshot all `i_cfg_*` into shadow registers and validate with a 32-bit unsigned check.
  - Invalid if `width_period==0` or `width_high>=width_period`.
  - Invalid: no bus writes; go to DONE with `o_error=1`.
  - Valid: clear `o_error`, set index=0, go to WRITE.
- **WRITE:** 17 writes, one per cycle, with `o_wr=1`.
  - Index 0: `BASE_ADDR` ← 0 (disable).
  - Index k=1..15: `BASE_ADDR+k` ← shadow field k. Multi-byte fields are written MSB byte first (YEAR_H = year[15:8]).
  - Index 16: `BASE_ADDR` ← `cfg_enable`.
  - Then go to READ if verify is compiled in, otherwise DONE.
- **DONE:** assert `o_done` for one cycle, then return to IDLE.
- **Busy and stall:** `o_busy = o_host_stall = (state==WRITE || state==READ)`. Outside IDLE, `o_wr` is driven only by the sequencer; host inputs are ignored.
- **Boundary conditions:**
  - `i_start` while not IDLE: ignored.
  - `i_start` and `i_host_wr` in the same IDLE cycle: the host write passes through that cycle; the sequence begins the next cycle.
  - Config inputs changing mid-sequence: no effect, because the snapshot is used.
  - `i_rst` low in any cycle: next state IDLE; all outputs and the shadow registers go to 0. The target may be left partially written and disabled, which is acceptable.
- **Reset values:** `o_wr=0`, `o_busy=0`, `o_done=0`, `o_error=0`, `o_host_stall=0`. `o_addr` and `o_data` follow the host inputs, because the state is IDLE.

## Timing
- Start sampled at edge 0.
- Writes occupy cycles 1..17: `o_wr` high for exactly 17 consecutive cycles.
- Without verify:
  - DONE in cycle 18; a new start is accepted from cycle 19.
  - Start-to-`o_done` latency is 18 cycles.
- Invalid config: `o_done` and `o_error` in cycle 1; no `o_wr`.
- READ (verify only):
  - Cycles 18..33 present `o_addr=BASE_ADDR+k` for k=0..15, with `o_wr=0`.
  - `i_rd_data` has one-cycle latency and is compared in cycles 19..34.
  - DONE in cycle 35; latency is 35 cycles.

## Configuration
- Macro: `PG_CONFIG_SEQ_VERIFY_EN`.
- **Defined:**
  - READ state is present.
  - Every read-back byte is compared to its expected value; offset 0 is compared to `cfg_enable`.
  - Any mismatch sets a sticky flag, which drives `o_error` at DONE.
- **Undefined:**
  - No READ state; `i_rd_data` is unused.
  - `o_error` reflects only validation failure.

## Test plan
- Host passthrough in IDLE: `i_host_wr=1`, addr `BASE_ADDR+3`, data 0x07 → same values on `o_*` in the same cycle; `o_host_stall=0`.
- Valid start with year=2024 (0x07E8), high=0x000F4240, period=0x00989680, enable=0x01 → 17 writes in order: ENA=0x00, YEAR_H=0x07, YEAR_L=0xE8, …, WP0=0x80, ENA=0x01. `o_done` at cycle 18 (35 with verify).
- Invalid config, high=period=100 → no `o_wr`; `o_done=1`, `o_error=1` at cycle 1.
- Host write and start in the same cycle, then host writes during the sequence → first host write passes through; the others are stalled and dropped; `o_host_stall` high for cycles 1..17.
- `i_rst` low at write index 8 → next cycle IDLE with all outputs at reset values; a new start then produces the full 17-write sequence.
- Verify build: target model corrupts the read-back of offset 5 → `o_error=1` with `o_done` at cycle 35. Without corruption → `o_error=0`.
